// File: rtl/noc_pkg.sv
// Shared flit layout, crossbar select codes and arbiter state encodings for the router input stage.
package noc_pkg;

    localparam int FLIT_W  = 8;
    localparam int DEST_HI = 7;
    localparam int DEST_LO = 4;

    localparam logic [2:0] SEL_IDLE     = 3'b000;
    localparam logic [2:0] SEL_NI_DOWN  = 3'b010;
    localparam logic [2:0] SEL_VC1_DOWN = 3'b011;
    localparam logic [2:0] SEL_VC0_NI   = 3'b100;

    typedef enum logic [1:0] {
        RR_VC0 = 2'd0,
        RR_VC1 = 2'd1,
        RR_NI  = 2'd2
    } rr_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VC0  = 2'd1,
        GNT_VC1  = 2'd2,
        GNT_NI   = 2'd3
    } grant_t;

endpackage

// File: rtl/vc_fifo.sv
// Single virtual-channel FIFO with a combinational head output and an occupancy count
// that is one bit wider than the pointers so that full and empty are distinct.
module vc_fifo #(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [FLIT_W-1:0]        din,
    output logic [FLIT_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the cleared pointers and count make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vc_input_alloc.sv
// Ring-router input stage: sorts upstream flits into eject/forward VC FIFOs, holds one NI flit,
// and grants one source per cycle to the crossbar. Define ROUTER_RR_ARB_EN for round-robin, else fixed priority.
module vc_input_alloc
    import noc_pkg::*;
#(
    parameter logic [3:0] NODE_ID = 4'd0,
    parameter int          DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               up_flit,
    input  logic                     up_valid,
    output logic                     up_ready,
    input  logic [7:0]               ni_flit,
    input  logic                     ni_valid,
    output logic                     ni_ready,
    input  logic                     down_ready,
    input  logic                     ni_out_ready,
    output logic [7:0]               vc0_out,
    output logic [7:0]               vc1_out,
    output logic [7:0]               ni_fwd,
    output logic                     sel_NI_out,
    output logic                     sel_vc,
    output logic                     sel_up,
    output logic [$clog2(DEPTH):0]   vc0_count,
    output logic [$clog2(DEPTH):0]   vc1_count
);

    logic              vc0_full, vc0_empty, vc1_full, vc1_empty;
    logic [FLIT_W-1:0] vc0_head, vc1_head;
    logic              up_accept, dest_local;
    logic              req_vc0, req_vc1, req_ni;
    logic [FLIT_W-1:0] ni_hold;
    logic              ni_hold_v;
    logic [2:0]        sel_q;
    grant_t            grant;

    assign up_ready   = !vc0_full && !vc1_full;
    assign ni_ready   = !ni_hold_v;
    assign up_accept  = up_valid && up_ready;
    assign dest_local = (up_flit[DEST_HI:DEST_LO] == NODE_ID);

    assign req_vc0 = !vc0_empty && ni_out_ready;
    assign req_vc1 = !vc1_empty && down_ready;
    assign req_ni  = ni_hold_v && down_ready;

    vc_fifo #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) u_vc0 (
        .clk(clk), .rst(rst),
        .push(up_accept && dest_local), .pop(grant == GNT_VC0),
        .din(up_flit), .dout(vc0_head),
        .full(vc0_full), .empty(vc0_empty), .count(vc0_count)
    );

    vc_fifo #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) u_vc1 (
        .clk(clk), .rst(rst),
        .push(up_accept && !dest_local), .pop(grant == GNT_VC1),
        .din(up_flit), .dout(vc1_head),
        .full(vc1_full), .empty(vc1_empty), .count(vc1_count)
    );

`ifdef ROUTER_RR_ARB_EN
    rr_state_t rr_q, rr_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_q <= RR_VC0;
        else      rr_q <= rr_d;
    end

    // Priority moves to the source after the winner; an idle cycle keeps it.
    always_comb begin
        rr_d = rr_q;
        case (grant)
            GNT_VC0: rr_d = RR_VC1;
            GNT_VC1: rr_d = RR_NI;
            GNT_NI:  rr_d = RR_VC0;
            default: rr_d = rr_q;
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        grant = GNT_NONE;
        case (rr_q)
            RR_VC1: begin
                if      (req_vc1) grant = GNT_VC1;
                else if (req_ni)  grant = GNT_NI;
                else if (req_vc0) grant = GNT_VC0;
            end
            RR_NI: begin
                if      (req_ni)  grant = GNT_NI;
                else if (req_vc0) grant = GNT_VC0;
                else if (req_vc1) grant = GNT_VC1;
            end
            default: begin
                if      (req_vc0) grant = GNT_VC0;
                else if (req_vc1) grant = GNT_VC1;
                else if (req_ni)  grant = GNT_NI;
            end
        endcase
    end
`else
    always_comb begin
        grant = GNT_NONE;
        if      (req_vc0) grant = GNT_VC0;
        else if (req_vc1) grant = GNT_VC1;
        else if (req_ni)  grant = GNT_NI;
    end
`endif

    // A held NI flit cannot be reloaded while held, so load and grant never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ni_hold   <= '0;
            ni_hold_v <= 1'b0;
        end else if (ni_valid && ni_ready) begin
            ni_hold   <= ni_flit;
            ni_hold_v <= 1'b1;
        end else if (grant == GNT_NI) begin
            ni_hold_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vc0_out <= '0;
            vc1_out <= '0;
            ni_fwd  <= '0;
            sel_q   <= SEL_IDLE;
        end else begin
            vc0_out <= (grant == GNT_VC0) ? vc0_head : '0;
            vc1_out <= (grant == GNT_VC1) ? vc1_head : '0;
            ni_fwd  <= (grant == GNT_NI)  ? ni_hold  : '0;
            case (grant)
                GNT_VC0: sel_q <= SEL_VC0_NI;
                GNT_VC1: sel_q <= SEL_VC1_DOWN;
                GNT_NI:  sel_q <= SEL_NI_DOWN;
                default: sel_q <= SEL_IDLE;
            endcase
        end
    end

    assign {sel_NI_out, sel_vc, sel_up} = sel_q;

endmodule

// File: tb/tb_vc_input_alloc.sv
// Directed self-checking bench for vc_input_alloc (NODE_ID = 3, DEPTH = 4); follows ROUTER_RR_ARB_EN like the RTL.
module tb_vc_input_alloc;

    localparam int         DEPTH = 4;
    localparam logic [3:0] NODE  = 4'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] up_flit = '0;
    logic       up_valid = 1'b0;
    logic       up_ready;
    logic [7:0] ni_flit = '0;
    logic       ni_valid = 1'b0;
    logic       ni_ready;
    logic       down_ready = 1'b0;
    logic       ni_out_ready = 1'b0;
    logic [7:0] vc0_out, vc1_out, ni_fwd;
    logic       sel_NI_out, sel_vc, sel_up;
    logic [2:0] vc0_count, vc1_count;
    logic [2:0] sel;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] rr_sel  [5];
    logic [7:0] rr_data [5];

    vc_input_alloc #(.NODE_ID(NODE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .up_flit(up_flit), .up_valid(up_valid), .up_ready(up_ready),
        .ni_flit(ni_flit), .ni_valid(ni_valid), .ni_ready(ni_ready),
        .down_ready(down_ready), .ni_out_ready(ni_out_ready),
        .vc0_out(vc0_out), .vc1_out(vc1_out), .ni_fwd(ni_fwd),
        .sel_NI_out(sel_NI_out), .sel_vc(sel_vc), .sel_up(sel_up),
        .vc0_count(vc0_count), .vc1_count(vc1_count)
    );

    assign sel = {sel_NI_out, sel_vc, sel_up};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " sel"}, 32'(sel), 32'h0);
        check({tag, " vc0_out"}, 32'(vc0_out), 32'h0);
        check({tag, " vc1_out"}, 32'(vc1_out), 32'h0);
        check({tag, " ni_fwd"}, 32'(ni_fwd), 32'h0);
    endtask

    initial begin
`ifdef ROUTER_RR_ARB_EN
        rr_sel  = '{3'b100, 3'b011, 3'b010, 3'b100, 3'b011};
        rr_data = '{8'h31, 8'h61, 8'hC7, 8'h32, 8'h62};
`else
        rr_sel  = '{3'b100, 3'b100, 3'b011, 3'b011, 3'b010};
        rr_data = '{8'h31, 8'h32, 8'h61, 8'h62, 8'hC7};
`endif

        // Reset state
        #1 rst = 1'b0;
        #2;
        check_idle("reset");
        check("reset up_ready", 32'(up_ready), 32'h1);
        check("reset ni_ready", 32'(ni_ready), 32'h1);
        check("reset vc0_count", 32'(vc0_count), 32'h0);
        check("reset vc1_count", 32'(vc1_count), 32'h0);
        tick();
        rst = 1'b1;

        // Basic eject then forward
        down_ready = 1'b1;
        ni_out_ready = 1'b1;
        up_flit = 8'h3A;
        up_valid = 1'b1;
        tick();
        check("basic vc0_count", 32'(vc0_count), 32'h1);
        up_flit = 8'h5B;
        tick();
        check("basic vc0_out", 32'(vc0_out), 32'h3A);
        check("basic sel eject", 32'(sel), 32'h4);
        check("basic vc1_count", 32'(vc1_count), 32'h1);
        up_valid = 1'b0;
        tick();
        check("basic vc1_out", 32'(vc1_out), 32'h5B);
        check("basic sel fwd", 32'(sel), 32'h3);
        check("basic vc0_out cleared", 32'(vc0_out), 32'h0);
        tick();
        check_idle("basic idle");

        // Fill VC1 while downstream is stalled, then drain in order
        down_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            up_flit = 8'h51 + 8'(i);
            up_valid = 1'b1;
            check("full up_ready before", 32'(up_ready), 32'h1);
            tick();
        end
        up_flit = 8'h55;
        check("full up_ready low", 32'(up_ready), 32'h0);
        check("full vc1_count", 32'(vc1_count), 32'h4);
        check_idle("full stalled");
        tick();
        check("full no overwrite count", 32'(vc1_count), 32'h4);
        up_valid = 1'b0;
        down_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            check("drain sel", 32'(sel), 32'h3);
            check("drain vc1_out", 32'(vc1_out), 32'(8'h51 + 8'(i)));
        end
        tick();
        check_idle("drain idle");
        check("drain vc1_count", 32'(vc1_count), 32'h0);
        check("drain up_ready", 32'(up_ready), 32'h1);

        // Simultaneous push and pop on VC1
        for (int i = 0; i < 5; i++) begin
            up_flit = 8'h71 + 8'(i);
            up_valid = 1'b1;
            tick();
            check("pushpop vc1_count", 32'(vc1_count), 32'h1);
            if (i > 0) check("pushpop vc1_out", 32'(vc1_out), 32'(8'h70 + 8'(i)));
        end
        up_valid = 1'b0;
        tick();
        check("pushpop last vc1_out", 32'(vc1_out), 32'h75);
        check("pushpop final count", 32'(vc1_count), 32'h0);

        // Reset in the middle of traffic
        down_ready = 1'b0;
        ni_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up_flit = 8'h31 + 8'(i);
            up_valid = 1'b1;
            ni_flit = 8'h9E;
            ni_valid = (i == 0);
            tick();
        end
        up_valid = 1'b0;
        ni_valid = 1'b0;
        check("midrst vc0_count filled", 32'(vc0_count), 32'h4);
        check("midrst ni_ready held", 32'(ni_ready), 32'h0);
        ni_out_ready = 1'b1;
        tick();
        check("midrst vc0_out", 32'(vc0_out), 32'h31);
        check("midrst sel", 32'(sel), 32'h4);
        check("midrst vc0_count", 32'(vc0_count), 32'h3);
        ni_out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check_idle("midrst asserted");
        check("midrst count0", 32'(vc0_count), 32'h0);
        check("midrst count1", 32'(vc1_count), 32'h0);
        check("midrst up_ready", 32'(up_ready), 32'h1);
        check("midrst ni_ready", 32'(ni_ready), 32'h1);
        #1 rst = 1'b1;
        down_ready = 1'b1;
        ni_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("post-reset idle");
        end

        // Arbitration with all three sources requesting
        down_ready = 1'b0;
        ni_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            up_flit = (i % 2 == 0) ? (8'h31 + 8'(i / 2)) : (8'h61 + 8'(i / 2));
            up_valid = 1'b1;
            ni_flit = 8'hC7;
            ni_valid = (i == 0);
            tick();
        end
        up_valid = 1'b0;
        ni_valid = 1'b0;
        check("arb vc0_count", 32'(vc0_count), 32'h2);
        check("arb vc1_count", 32'(vc1_count), 32'h2);
        down_ready = 1'b1;
        ni_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("arb sel", 32'(sel), 32'(rr_sel[i]));
            check("arb vc0_out", 32'(vc0_out), (rr_sel[i] == 3'b100) ? 32'(rr_data[i]) : 32'h0);
            check("arb vc1_out", 32'(vc1_out), (rr_sel[i] == 3'b011) ? 32'(rr_data[i]) : 32'h0);
            check("arb ni_fwd", 32'(ni_fwd), (rr_sel[i] == 3'b010) ? 32'(rr_data[i]) : 32'h0);
        end
        tick();
        check_idle("arb idle");
        check("arb ni_ready", 32'(ni_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
